// File: rtl/pipe_spawn_ctrl.sv
// Pipe spawn controller: sequences the LFSR, reduces each sample to a legal gap height
// and maintains a 4-entry scrolling pipe slot table for the renderer and collision logic.
module pipe_spawn_ctrl #(
  parameter int unsigned SPAWN_PERIOD = 90,
  parameter int unsigned SPAWN_X      = 640,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned GAP_MIN      = 100,
  parameter int unsigned GAP_MAX      = 355
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        game_over,
  input  logic        tick,
  input  logic [9:0]  rand_num,
  output logic        rng_reseed,
  output logic        running,
  output logic [3:0]  pipe_valid,
  output logic [39:0] pipe_x,
  output logic [39:0] pipe_gap,
  output logic        spawn_drop
);

  localparam int unsigned RANGE = GAP_MAX - GAP_MIN + 1;
  localparam int unsigned CNT_W = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [9:0]       RANGE_V   = 10'(RANGE);
  localparam logic [9:0]       SPEED_V   = 10'(SPEED);
  localparam logic [9:0]       SPAWN_X_V = 10'(SPAWN_X);
  localparam logic [9:0]       GAP_MIN_V = 10'(GAP_MIN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RUN, REDUCE, OVER} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       rem;
  logic [1:0]       free_idx;
  logic             free_any;

  // Lowest-index empty slot, judged on the table as it stands before this edge.
  always_comb begin
    free_any = 1'b0;
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pipe_valid[i]) begin
        free_any = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      pipe_valid <= '0;
      pipe_x     <= '0;
      pipe_gap   <= '0;
      rng_reseed <= 1'b0;
      running    <= 1'b0;
      spawn_drop <= 1'b0;
    end else begin
      rng_reseed <= 1'b0;
      spawn_drop <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start && (state == IDLE || !game_over)) begin
            state      <= RUN;
            running    <= 1'b1;
            rng_reseed <= 1'b1;
            cnt        <= '0;
            pipe_valid <= '0;
            pipe_x     <= '0;
            pipe_gap   <= '0;
          end
        end
        RUN, REDUCE: begin
          if (game_over) begin
            // Freeze the playfield; any reduction in flight is dropped.
            state   <= OVER;
            running <= 1'b0;
          end else begin
            if (tick) begin
              for (int i = 0; i < 4; i++) begin
                if (pipe_valid[i]) begin
                  if (pipe_x[10*i +: 10] < SPEED_V) pipe_valid[i] <= 1'b0;
                  else pipe_x[10*i +: 10] <= pipe_x[10*i +: 10] - SPEED_V;
                end
              end
              if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (state == RUN) begin
                  rem   <= rand_num;
                  state <= REDUCE;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            // Modulo by repeated subtraction, one step per cycle.
            if (state == REDUCE) begin
              if (rem >= RANGE_V) begin
                rem <= rem - RANGE_V;
              end else begin
                state <= RUN;
                if (free_any) begin
                  for (int i = 0; i < 4; i++) begin
                    if (free_idx == 2'(i)) begin
                      pipe_valid[i]        <= 1'b1;
                      pipe_x[10*i +: 10]   <= SPAWN_X_V;
                      pipe_gap[10*i +: 10] <= GAP_MIN_V + rem;
                    end
                  end
                end else begin
                  spawn_drop <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
